// File: rtl/pipe_skid_stage_pkg.sv
// pipe_skid_stage_pkg: shared NOP encoding and skid-stage occupancy states
package rv32i_types;
   localparam logic [31:0] NOP_INSN = 32'h0000_0013;
endpackage

package pipe_skid_stage_pkg;
   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_FULL  = 2'd2
   } occ_e;
endpackage

// File: rtl/pipe_skid_stage_if.sv
// pipe_skid_stage_if: upstream/downstream handshake bundle for the skid stage
interface pipe_skid_stage_if #(
   parameter int WIDTH = 32
) ();
   logic             flush;
   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic             in_ready;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic             out_ready;
   logic [1:0]       count;
   modport master (
      output flush, in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, count
   );
   modport slave (
      input  flush, in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, count
   );
endinterface

// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: two-entry skid buffer between pipeline stages with flush/bubble support
module pipe_skid_stage
   import rv32i_types::*;
   import pipe_skid_stage_pkg::*;
#(
   parameter int               WIDTH      = 32,
   parameter logic [WIDTH-1:0] BUBBLE     = WIDTH'(NOP_INSN),
   parameter int               FLUSH_MODE = 0
) (
   input logic              clk,
   input logic              rst_n,
   pipe_skid_stage_if.slave bus
);
   occ_e             r_state;
   occ_e             w_state_nxt;
   logic [WIDTH-1:0] r_slot0;
   logic [WIDTH-1:0] r_slot1;
   logic [WIDTH-1:0] w_slot0_nxt;
   logic [WIDTH-1:0] w_slot1_nxt;
   logic             w_push;
   logic             w_pop;
   // Handshake outputs depend only on registered occupancy; unused slots always hold BUBBLE
   assign bus.in_ready  = (r_state != S_FULL);
   assign bus.out_valid = (r_state != S_EMPTY);
   assign bus.out_data  = r_slot0;
   assign bus.count     = r_state;
   assign w_push        = bus.in_valid & bus.in_ready;
   assign w_pop         = bus.out_valid & bus.out_ready;
   // State and payload registers; reset empties the stage and refills both slots with BUBBLE
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_EMPTY;
         r_slot0 <= BUBBLE;
         r_slot1 <= BUBBLE;
      end else begin
         r_state <= w_state_nxt;
         r_slot0 <= w_slot0_nxt;
         r_slot1 <= w_slot1_nxt;
      end
   end
   // Next occupancy/payload: FIFO push/pop first, then flush drops or bubbles what remains
   always_comb begin
      w_state_nxt = r_state;
      w_slot0_nxt = r_slot0;
      w_slot1_nxt = r_slot1;
      case (r_state)
         S_EMPTY: begin
            if (w_push) begin
               w_state_nxt = S_ONE;
               w_slot0_nxt = bus.in_data;
            end
         end
         S_ONE: begin
            if (w_push && w_pop) begin
               w_slot0_nxt = bus.in_data;
            end else if (w_push) begin
               w_state_nxt = S_FULL;
               w_slot1_nxt = bus.in_data;
            end else if (w_pop) begin
               w_state_nxt = S_EMPTY;
               w_slot0_nxt = BUBBLE;
            end
         end
         S_FULL: begin
            if (w_pop) begin
               w_state_nxt = S_ONE;
               w_slot0_nxt = r_slot1;
               w_slot1_nxt = BUBBLE;
            end
         end
         default: begin
            w_state_nxt = S_EMPTY;
            w_slot0_nxt = BUBBLE;
            w_slot1_nxt = BUBBLE;
         end
      endcase
      if (bus.flush) begin
         w_slot0_nxt = BUBBLE;
         w_slot1_nxt = BUBBLE;
         if (FLUSH_MODE == 0) w_state_nxt = S_EMPTY;
      end
   end
endmodule

// File: tb/tb_pipe_skid_stage.sv
// tb_pipe_skid_stage: directed and random checks of the skid stage against a list model
module tb_pipe_skid_stage;
   localparam logic [31:0] NOP = 32'h0000_0013;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic [31:0] in_data;
   logic        out_ready;
   logic [31:0] m_d [2][2];
   int          m_n [2];
   int          n_chk = 0;
   int          n_pass = 0;
   always #5 clk = ~clk;
   pipe_skid_stage_if #(.WIDTH(32)) i0 ();
   pipe_skid_stage_if #(.WIDTH(32)) i1 ();
   pipe_skid_stage_if #(.WIDTH(64)) i64 ();
   assign i0.flush     = flush;
   assign i0.in_valid  = in_valid;
   assign i0.in_data   = in_data;
   assign i0.out_ready = out_ready;
   assign i1.flush     = flush;
   assign i1.in_valid  = in_valid;
   assign i1.in_data   = in_data;
   assign i1.out_ready = out_ready;
   pipe_skid_stage #(.WIDTH(32), .FLUSH_MODE(0)) d0 (.clk(clk), .rst_n(rst_n), .bus(i0));
   pipe_skid_stage #(.WIDTH(32), .FLUSH_MODE(1)) d1 (.clk(clk), .rst_n(rst_n), .bus(i1));
   pipe_skid_stage #(.WIDTH(64), .FLUSH_MODE(0)) d64 (.clk(clk), .rst_n(rst_n), .bus(i64));
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
   endtask
   task automatic step();
      bit          pu;
      bit          po;
      logic [31:0] exp_d;
      @(posedge clk);
      for (int m = 0; m < 2; m++) begin
         if (!rst_n) m_n[m] = 0;
         else begin
            po = out_ready && m_n[m] > 0;
            pu = in_valid && m_n[m] < 2;
            if (po) begin
               m_d[m][0] = m_d[m][1];
               m_n[m]--;
            end
            if (pu) begin
               m_d[m][m_n[m]] = in_data;
               m_n[m]++;
            end
            if (flush) begin
               if (m == 0) m_n[m] = 0;
               else begin
                  m_d[m][0] = NOP;
                  m_d[m][1] = NOP;
               end
            end
         end
      end
      #1;
      for (int m = 0; m < 2; m++) begin
         exp_d = (m_n[m] > 0) ? m_d[m][0] : NOP;
         chk($sformatf("count_m%0d", m), (m == 0) ? 64'(i0.count) : 64'(i1.count), 64'(m_n[m]));
         chk($sformatf("out_valid_m%0d", m), (m == 0) ? 64'(i0.out_valid) : 64'(i1.out_valid), 64'(m_n[m] != 0));
         chk($sformatf("in_ready_m%0d", m), (m == 0) ? 64'(i0.in_ready) : 64'(i1.in_ready), 64'(m_n[m] != 2));
         chk($sformatf("out_data_m%0d", m), (m == 0) ? 64'(i0.out_data) : 64'(i1.out_data), 64'(exp_d));
      end
   endtask
   task automatic drive(input logic v, input logic [31:0] d, input logic r, input logic f);
      in_valid  = v;
      in_data   = d;
      out_ready = r;
      flush     = f;
   endtask
   initial begin
      rst_n = 1'b0;
      m_n[0] = 0;
      m_n[1] = 0;
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      i64.flush     = 1'b0;
      i64.in_valid  = 1'b0;
      i64.in_data   = 64'h0;
      i64.out_ready = 1'b0;
      step();
      step();
      chk("rst_data", 64'(i0.out_data), 64'h13);
      rst_n = 1'b1;
      drive(1'b1, 32'hA000_0001, 1'b1, 1'b0);
      step();
      chk("stream_a", 64'(i0.out_data), 64'hA000_0001);
      drive(1'b1, 32'hB000_0002, 1'b1, 1'b0);
      step();
      chk("stream_b", 64'(i0.out_data), 64'hB000_0002);
      drive(1'b1, 32'hC000_0003, 1'b1, 1'b0);
      step();
      chk("stream_c", 64'(i0.out_data), 64'hC000_0003);
      chk("stream_cnt", 64'(i0.count), 64'd1);
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      step();
      drive(1'b1, 32'hA1, 1'b0, 1'b0);
      step();
      drive(1'b1, 32'hB2, 1'b0, 1'b0);
      step();
      drive(1'b1, 32'hC3, 1'b0, 1'b0);
      step();
      step();
      chk("bp_cnt", 64'(i0.count), 64'd2);
      chk("bp_rdy", 64'(i0.in_ready), 64'd0);
      drive(1'b1, 32'hC3, 1'b1, 1'b0);
      step();
      chk("bp_b", 64'(i0.out_data), 64'hB2);
      step();
      chk("bp_c", 64'(i0.out_data), 64'hC3);
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      step();
      chk("bp_empty", 64'(i0.count), 64'd0);
      drive(1'b1, 32'hA4, 1'b0, 1'b0);
      step();
      drive(1'b1, 32'hB5, 1'b0, 1'b0);
      step();
      drive(1'b1, 32'hC6, 1'b0, 1'b1);
      step();
      chk("fl0_cnt", 64'(i0.count), 64'd0);
      chk("fl0_valid", 64'(i0.out_valid), 64'd0);
      chk("fl0_data", 64'(i0.out_data), 64'h13);
      chk("fl1_keep_cnt", 64'(i1.count), 64'd2);
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      step();
      step();
      drive(1'b1, 32'hA7, 1'b0, 1'b0);
      step();
      drive(1'b1, 32'hB8, 1'b0, 1'b0);
      step();
      drive(1'b0, 32'h0, 1'b1, 1'b1);
      step();
      chk("fl1_cnt", 64'(i1.count), 64'd1);
      chk("fl1_valid", 64'(i1.out_valid), 64'd1);
      chk("fl1_data", 64'(i1.out_data), 64'h13);
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      step();
      drive(1'b1, 32'hA9, 1'b0, 1'b0);
      step();
      drive(1'b1, 32'hBA, 1'b0, 1'b0);
      step();
      rst_n = 1'b0;
      drive(1'b1, 32'hCB, 1'b1, 1'b1);
      step();
      chk("rstmid_cnt", 64'(i0.count), 64'd0);
      chk("rstmid_rdy", 64'(i1.in_ready), 64'd1);
      chk("rstmid_valid", 64'(i1.out_valid), 64'd0);
      rst_n = 1'b1;
      drive(1'b1, 32'hDC, 1'b0, 1'b0);
      step();
      chk("post_rst_push", 64'(i0.out_data), 64'hDC);
      for (int c = 0; c < 2000; c++) begin
         rst_n = ($urandom_range(63) != 0);
         drive(1'($urandom_range(1)), $urandom, 1'($urandom_range(1)), $urandom_range(15) == 0);
         step();
      end
      rst_n = 1'b1;
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      step();
      step();
      chk("w64_idle_data", i64.out_data, 64'h0000_0000_0000_0013);
      chk("w64_idle_cnt", 64'(i64.count), 64'd0);
      i64.in_valid = 1'b1;
      i64.in_data  = 64'hDEAD_BEEF_CAFE_F00D;
      step();
      i64.in_valid = 1'b0;
      chk("w64_data", i64.out_data, 64'hDEAD_BEEF_CAFE_F00D);
      chk("w64_valid", 64'(i64.out_valid), 64'd1);
      i64.out_ready = 1'b1;
      step();
      chk("w64_bubble", i64.out_data, 64'h0000_0000_0000_0013);
      chk("w64_cnt", 64'(i64.count), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/pipe_skid_stage.md
PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 32, payload width in bits.
REQ-002 SHALL have parameter BUBBLE, default 32'h00000013 zero-extended/truncated to WIDTH, payload substituted on bubble-mode flush.
REQ-003 SHALL have parameter FLUSH_MODE, default 0, 0 = drop held entries, 1 = keep entries valid but overwrite payload with BUBBLE.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-006 SHALL have port flush  input  1  kill/bubble request, one cycle.
REQ-007 SHALL have port in_valid  input  1  upstream payload valid.
REQ-008 SHALL have port in_data  input  WIDTH  upstream payload.
REQ-009 SHALL have port in_ready  output  1  stage can accept this cycle.
REQ-010 SHALL have port out_valid  output  1  head entry valid.
REQ-011 SHALL have port out_data  output  WIDTH  head entry payload.
REQ-012 SHALL have port out_ready  input  1  downstream accepts head.
REQ-013 SHALL have port count  output  2  entries held, 0..2.

Function
REQ-014 SHALL hold up to 2 entries in FIFO order: slot 0 = head, slot 1 = skid.
REQ-015 SHALL define push = in_valid & in_ready, pop = out_valid & out_ready, sampled at the rising edge.
REQ-016 SHALL drive in_ready = (count != 2), a function of registered state only; no combinational path from out_ready.
REQ-017 SHALL drive out_valid = (count != 0) and out_data = slot 0; out_data SHALL equal BUBBLE when count == 0.
REQ-018 SHALL give 1-cycle latency: a push into an empty stage appears on out_valid/out_data the next cycle.
REQ-019 SHALL sustain one transfer per cycle: push and pop together at count 1 leave count 1, with slot 0 taking in_data.
REQ-020 SHALL, at count 2, accept no push; a pop moves slot 1 into slot 0 and count becomes 1.
REQ-021 SHALL, on pop without push at count 1, clear count to 0.
REQ-022 SHALL, with FLUSH_MODE 0 and flush high, set count to 0 next cycle and discard both held entries and any same-cycle push; pop that cycle still counts as delivered.
REQ-023 SHALL, with FLUSH_MODE 1 and flush high, set every entry that remains after the same-cycle pop to BUBBLE payload and keep count unchanged. A same-cycle push SHALL be stored as BUBBLE.
REQ-024 SHALL not change payload or count when neither push, pop nor flush occurs (stall holds).
REQ-025 SHALL ignore in_data when in_valid is low.

Reset
REQ-026 SHALL, on rst_n low at a rising edge, set count 0, out_valid 0, in_ready 1, out_data BUBBLE, both slots BUBBLE.
REQ-027 SHALL let reset override flush, push and pop in the same cycle; an in-flight entry is lost.
REQ-028 SHALL, after rst_n returns high, accept a push on the first edge.

Structure
REQ-029 SHALL place the default NOP encoding constant (32'h00000013) in rv32i_types and reference it for BUBBLE.
REQ-030 SHALL be a single module with no sub-modules. Multi-field stage payloads are packed into WIDTH by the instantiating stage wrapper (if_id/id_ex/ex_mem/mem_wb successors).

Verification
REQ-031 SHALL cover streaming with out_ready held 1: push A,B,C on consecutive cycles -> out_data A,B,C on the next three cycles, count stays 1, in_ready stays 1.
REQ-032 SHALL cover backpressure: out_ready 0, push A,B -> count 2, in_ready 0, C is held upstream; raise out_ready -> A,B,C delivered in order, nothing lost or duplicated.
REQ-033 SHALL cover FLUSH_MODE 0 drop: count 2 holding A,B, flush with in_valid C -> next cycle count 0, out_valid 0, out_data 32'h00000013.
REQ-034 SHALL cover FLUSH_MODE 1 bubble: count 2, flush with pop -> A delivered, next cycle count 1 with out_data 32'h00000013, out_valid 1.
REQ-035 SHALL cover reset mid-operation: count 2, rst_n low with push and flush -> count 0, in_ready 1, out_valid 0 next cycle.
REQ-036 SHALL cover a WIDTH=64 instance: 64-bit payload 64'hDEADBEEF_CAFEF00D passes intact, and BUBBLE zero-extends to 64'h0000000000000013.
